// File: rtl/d_latch_unit_pkg.sv
// Shared helpers for the d_latch_unit storage cell: the transparent/hold
// output selection used by every bit slice.
package d_latch_unit_pkg;

   function automatic logic latch_sel(input logic en, input logic d, input logic held);
      return en ? d : held;
   endfunction

endpackage

// File: rtl/d_latch_unit_bit.sv
// One-bit clocked latch cell: a flop captures data while enabled, and the
// output bypasses the flop combinationally while transparent.
module d_latch_unit_bit
   import d_latch_unit_pkg::*;
#(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic data,
   output logic q,
   output logic q_not
);

   logic held_q;
   logic held_d;

   always_comb begin
      held_d = enable ? data : held_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_q <= RESET_VAL;
      end else begin
         held_q <= held_d;
      end
   end

   // Transparency is deliberately not gated by reset: only the stored value is.
   always_comb begin
      q     = latch_sel(enable, data, held_q);
      q_not = ~latch_sel(enable, data, held_q);
   end

endmodule

// File: rtl/d_latch_unit.sv
// Clock-synchronous emulation of a transparent D latch with true and
// complement outputs; WIDTH independent bit cells share enable and reset.
module d_latch_unit
   import d_latch_unit_pkg::*;
#(
   parameter int unsigned          WIDTH     = 1,
   parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_not,
   output logic             transparent
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      d_latch_unit_bit #(
         .RESET_VAL (RESET_VAL[i])
      ) u_bit (
         .clk    (clk),
         .rst_n  (rst_n),
         .enable (enable),
         .data   (data[i]),
         .q      (q[i]),
         .q_not  (q_not[i])
      );
   end

   always_comb begin
      transparent = enable;
   end

endmodule

// File: tb/tb_d_latch_unit.sv
// Scoreboard bench for d_latch_unit: stimulus pushes the expected outputs of a
// behavioural latch model, a negedge monitor pops and compares.
module tb_d_latch_unit;

   localparam int unsigned      W  = 8;
   localparam logic [W-1:0]     RV = 8'hA5;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] qn;
      logic         tr;
      string        tag;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         enable;
   logic [W-1:0] data;
   logic [W-1:0] q;
   logic [W-1:0] q_not;
   logic         transparent;

   exp_t         sb[$];
   int           n_vec = 0;
   int           n_mis = 0;

   // reference model state: the value a real latch would be remembering
   logic [W-1:0] mem;
   logic         cur_rst;
   logic         cur_en;
   logic [W-1:0] cur_d;

   d_latch_unit #(
      .WIDTH     (W),
      .RESET_VAL (RV)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .data        (data),
      .q           (q),
      .q_not       (q_not),
      .transparent (transparent)
   );

   always #5 clk = ~clk;

   // One cycle of stimulus: account for the edge just taken, then drive new
   // inputs shortly after it and predict what the outputs must show.
   task automatic step(input logic rst, input logic en, input logic [W-1:0] d, input string tag);
      exp_t e;
      @(posedge clk);
      if (cur_rst && cur_en) mem = cur_d;
      #1;
      rst_n   = rst;
      enable  = en;
      data    = d;
      cur_rst = rst;
      cur_en  = en;
      cur_d   = d;
      if (!rst) mem = RV;
      e.q   = en ? d : mem;
      e.qn  = ~e.q;
      e.tr  = en;
      e.tag = tag;
      sb.push_back(e);
   endtask

   // Monitor: outputs are combinational, so each driven cycle presents one
   // response, sampled mid-cycle on the falling edge.
   initial begin
      exp_t e;
      logic bad;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e   = sb.pop_front();
            bad = 1'b0;
            n_vec++;
            if (q !== e.q) begin
               $display("FAIL %s q: got %h expected %h", e.tag, q, e.q);
               bad = 1'b1;
            end
            if (q_not !== e.qn) begin
               $display("FAIL %s q_not: got %h expected %h", e.tag, q_not, e.qn);
               bad = 1'b1;
            end
            if (transparent !== e.tr) begin
               $display("FAIL %s transparent: got %b expected %b", e.tag, transparent, e.tr);
               bad = 1'b1;
            end
            if (bad) n_mis++;
         end
      end
   end

   initial begin
      logic r;
      logic en;
      rst_n   = 1'b1;
      enable  = 1'b0;
      data    = '0;
      cur_rst = 1'b1;
      cur_en  = 1'b0;
      cur_d   = '0;
      mem     = 'x;

      step(1'b0, 1'b0, 8'h00, "reset_idle");
      step(1'b0, 1'b0, 8'h00, "reset_idle2");
      step(1'b1, 1'b0, 8'h00, "release_idle");
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'hFF, "data_no_enable");
      step(1'b1, 1'b1, 8'h01, "enable_data1");
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h00, "hold_after_enable");
      step(1'b1, 1'b1, 8'h00, "enable_data0");
      step(1'b1, 1'b0, 8'hEE, "hold_zero");
      step(1'b1, 1'b1, 8'h3C, "capture_3c");
      step(1'b1, 1'b0, 8'h77, "hold_3c");
      step(1'b1, 1'b0, 8'h12, "hold_3c_b");
      step(1'b0, 1'b0, 8'h34, "async_reset_midhold");
      step(1'b1, 1'b0, 8'h56, "after_release");
      step(1'b1, 1'b0, 8'h9A, "after_release_b");
      step(1'b0, 1'b1, 8'h5E, "reset_transparent");
      step(1'b0, 1'b1, 8'hC3, "reset_transparent_b");
      step(1'b1, 1'b0, 8'h00, "release_keeps_rv");
      step(1'b1, 1'b1, 8'hF0, "falling_edge_cap");
      step(1'b1, 1'b1, 8'h0F, "falling_edge_late");
      step(1'b1, 1'b0, 8'hAA, "steps_back_to_sample");

      for (int i = 0; i < 300; i++) begin
         r  = ($urandom_range(0, 19) != 0);
         en = $urandom_range(0, 1) == 1;
         step(r, en, W'($urandom), "random");
      end

      for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         $display("FAIL drain: got %0d pending expected 0", sb.size());
         n_mis++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
